// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix arithmetic datapath: element/bus
// widths, the operand bus type and the loader FSM encoding.
package matrix_pkg;

  localparam int ELEM_W      = 8;
  localparam int MAT_ELEMS   = 25;
  localparam int MAT_W       = ELEM_W * MAT_ELEMS;
  localparam int WORD_W      = 32;
  localparam int LAST_A_WORD = 6;
  localparam int LAST_B_WORD = 13;
  localparam int WCNT_W      = 4;

  typedef logic [MAT_W-1:0] mat_bus_t;

  typedef enum logic [1:0] {
    FILL_A = 2'd0,
    FILL_B = 2'd1,
    HOLD   = 2'd2
  } load_state_t;

endpackage

// File: rtl/matrix_frame_loader_word_to_elems.sv
// Byte-slot writer: merges one accepted 32-bit word into a staged matrix at
// the element slots owned by the current word index.
module word_to_elems
  import matrix_pkg::*;
#(
  parameter int BASE = 0
) (
  input  logic              we,
  input  logic [WCNT_W-1:0] wcnt,
  input  logic [WORD_W-1:0] wr_data,
  input  mat_bus_t          cur,
  output mat_bus_t          nxt
);

  generate
    for (genvar gi = 0; gi < MAT_ELEMS; gi++) begin : g_elem
      localparam int WORD = gi / 4;
      localparam int LANE = gi % 4;
      // Element 24 takes only byte 0 of the last word; its upper lanes map nowhere.
      assign nxt[ELEM_W*gi +: ELEM_W] =
        (we && (wcnt == WCNT_W'(BASE + WORD))) ? wr_data[ELEM_W*LANE +: ELEM_W]
                                               : cur[ELEM_W*gi +: ELEM_W];
    end
  endgenerate

endmodule

// File: rtl/matrix_frame_loader.sv
// Double-buffered loader of two 5x5 int8 operand matrices from a 32-bit word
// stream. Optional sticky error detection is enabled with LOAD_ERR_EN.
module matrix_frame_loader
  import matrix_pkg::*;
#(
  parameter int ELEMS = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  input  logic [31:0]        wr_data,
  output logic               wr_ready,
  input  logic               flush,
  output logic [8*ELEMS-1:0] mat_a,
  output logic [8*ELEMS-1:0] mat_b,
  output logic               mat_valid,
  input  logic               mat_ready,
  output logic [7:0]         frame_cnt,
  output logic               load_err
);

  localparam int WORDS  = (ELEMS + 3) / 4;
  localparam int LAST_A = WORDS - 1;
  localparam int LAST_B = 2 * WORDS - 1;

  load_state_t       state_reg, state_next;
  logic [WCNT_W-1:0] wcnt_reg;
  mat_bus_t          stg_a_reg, stg_b_reg, stg_a_next, stg_b_next;
  mat_bus_t          mat_a_reg, mat_b_reg;
  logic              mat_valid_reg;
  logic [7:0]        frame_cnt_reg;
  logic              full, accept, commit;

  assign full   = (state_reg == HOLD);
  assign accept = wr_valid && !full && !flush;
  // Flush outranks commit so a staged frame can be discarded from HOLD.
  assign commit = full && (!mat_valid_reg || mat_ready) && !flush;

  word_to_elems #(.BASE(0)) u_wr_a (
    .we      (accept),
    .wcnt    (wcnt_reg),
    .wr_data (wr_data),
    .cur     (stg_a_reg),
    .nxt     (stg_a_next)
  );

  word_to_elems #(.BASE(LAST_A_WORD + 1)) u_wr_b (
    .we      (accept),
    .wcnt    (wcnt_reg),
    .wr_data (wr_data),
    .cur     (stg_b_reg),
    .nxt     (stg_b_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FILL_A;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = FILL_A;
    end else begin
      case (state_reg)
        FILL_A: if (accept && wcnt_reg == WCNT_W'(LAST_A)) state_next = FILL_B;
        FILL_B: if (accept && wcnt_reg == WCNT_W'(LAST_B)) state_next = HOLD;
        HOLD:   if (commit) state_next = FILL_A;
        default: state_next = FILL_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_reg      <= '0;
      stg_a_reg     <= '0;
      stg_b_reg     <= '0;
      mat_a_reg     <= '0;
      mat_b_reg     <= '0;
      mat_valid_reg <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      stg_a_reg <= stg_a_next;
      stg_b_reg <= stg_b_next;

      if (flush) begin
        wcnt_reg <= '0;
      end else if (accept) begin
        wcnt_reg <= (wcnt_reg == WCNT_W'(LAST_B)) ? '0 : wcnt_reg + 1'b1;
      end

      if (commit) begin
        mat_a_reg     <= stg_a_reg;
        mat_b_reg     <= stg_b_reg;
        mat_valid_reg <= 1'b1;
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end else if (mat_valid_reg && mat_ready) begin
        mat_valid_reg <= 1'b0;
      end
    end
  end

  assign wr_ready  = !full;
  assign mat_a     = mat_a_reg;
  assign mat_b     = mat_b_reg;
  assign mat_valid = mat_valid_reg;
  assign frame_cnt = frame_cnt_reg;

`ifdef LOAD_ERR_EN
  logic load_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      load_err_reg <= 1'b0;
    end else if ((accept && (wcnt_reg == WCNT_W'(LAST_A) || wcnt_reg == WCNT_W'(LAST_B))
                  && (|wr_data[31:8])) || (wr_valid && full)) begin
      load_err_reg <= 1'b1;
    end
  end

  assign load_err = load_err_reg;
`else
  assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_frame_loader.sv
// Directed bench for matrix_frame_loader with a frame scoreboard; build with
// LOAD_ERR_EN defined to exercise the error flag.
module tb_matrix_frame_loader;
  import matrix_pkg::*;

  logic         clk = 1'b0;
  logic         rst, wr_valid, flush, mat_ready;
  logic [31:0]  wr_data;
  logic         wr_ready, mat_valid, load_err;
  logic [199:0] mat_a, mat_b;
  logic [7:0]   frame_cnt;

  int checks = 0;
  int failures = 0;
  int tb_cnt = 0;
  mat_bus_t   exp_a[$];
  mat_bus_t   exp_b[$];
  logic [7:0] exp_c[$];

  matrix_frame_loader dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .flush     (flush),
    .mat_a     (mat_a),
    .mat_b     (mat_b),
    .mat_valid (mat_valid),
    .mat_ready (mat_ready),
    .frame_cnt (frame_cnt),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(mat_bus_t a, mat_bus_t b, int k, logic [23:0] hi6);
    mat_bus_t m;
    int idx;
    m   = (k < 7) ? a : b;
    idx = (k < 7) ? k : k - 7;
    if (idx < 6) return m[32*idx +: 32];
    return {((k == 6) ? hi6 : 24'h0), m[199:192]};
  endfunction

  function automatic mat_bus_t rand_mat();
    mat_bus_t m;
    for (int w = 0; w < 6; w++) m[32*w +: 32] = $urandom;
    m[199:192] = 8'($urandom_range(0, 255));
    return m;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!wr_ready && n < 40) begin
      step();
      n++;
    end
    if (!wr_ready) check("wr_ready_timeout", wr_ready, 1);
  endtask

  task automatic send_words(input mat_bus_t a, input mat_bus_t b, input logic [23:0] hi6,
                            input int first, input int last);
    for (int k = first; k <= last; k++) begin
      wr_data  = word_of(a, b, k, hi6);
      wr_valid = 1'b1;
      wait_ready();
      step();
    end
    wr_valid = 1'b0;
  endtask

  task automatic push_frame(input mat_bus_t a, input mat_bus_t b);
    tb_cnt++;
    exp_a.push_back(a);
    exp_b.push_back(b);
    exp_c.push_back(8'(tb_cnt));
  endtask

  task automatic check_commit(input string tag);
    mat_bus_t ea, eb;
    logic [7:0] ec;
    check({tag, "_sb_nonempty"}, 200'(exp_a.size() > 0), 1);
    if (exp_a.size() > 0) begin
      ea = exp_a.pop_front();
      eb = exp_b.pop_front();
      ec = exp_c.pop_front();
      check({tag, "_valid"}, mat_valid, 1);
      check({tag, "_mat_a"}, mat_a, ea);
      check({tag, "_mat_b"}, mat_b, eb);
      check({tag, "_cnt"}, frame_cnt, ec);
    end
    $display("commit %s frame_cnt=%0d", tag, frame_cnt);
  endtask

  initial begin
    mat_bus_t a1, b1, a2, b2, a3, b3, ar, br;
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; flush = 1'b0; mat_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_wr_ready", wr_ready, 1);
    check("rst_mat_valid", mat_valid, 0);
    check("rst_mat_a", mat_a, 0);
    check("rst_mat_b", mat_b, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_load_err", load_err, 0);
    $display("reset done");

    // Basic load: A[i] = i+1, B = all 0xFF
    for (int i = 0; i < 25; i++) a1[8*i +: 8] = 8'(i + 1);
    b1 = '1;
    push_frame(a1, b1);
    send_words(a1, b1, 24'h0, 0, 13);
    check("basic_hold_valid", mat_valid, 0);
    check("basic_hold_ready", wr_ready, 0);
    step();
    check_commit("basic");
    check("basic_a_lo", mat_a[7:0], 8'h01);
    check("basic_a_hi", mat_a[199:192], 8'h19);
    check("basic_ready_after", wr_ready, 1);

    // Backpressure: frame 2 waits for mat_ready, then back-to-back commit
    a2 = rand_mat(); b2 = rand_mat();
    push_frame(a2, b2);
    send_words(a2, b2, 24'h0, 0, 13);
    step(); step();
    check("bp_ready_low", wr_ready, 0);
    check("bp_hold_a", mat_a, a1);
    check("bp_hold_cnt", frame_cnt, 1);
    mat_ready = 1'b1;
    step();
    mat_ready = 1'b0;
    check_commit("backpressure");
    step();
    check("bp_still_valid", mat_valid, 1);
    mat_ready = 1'b1;
    step();
    mat_ready = 1'b0;
    check("bp_release_valid", mat_valid, 0);
    check("bp_release_keep_a", mat_a, a2);

    // Flush on word 9 drops the partial frame
    a3 = rand_mat(); b3 = rand_mat();
    send_words(a3, b3, 24'h0, 0, 8);
    wr_data = word_of(a3, b3, 9, 24'h0); wr_valid = 1'b1; flush = 1'b1;
    step();
    wr_valid = 1'b0; flush = 1'b0;
    check("flush_keep_a", mat_a, a2);
    check("flush_keep_cnt", frame_cnt, 2);
    check("flush_ready", wr_ready, 1);
    $display("flush mid-frame");
    a3 = rand_mat(); b3 = rand_mat();
    push_frame(a3, b3);
    send_words(a3, b3, 24'h0, 0, 13);
    step();
    check_commit("after_flush");

    // Flush in HOLD beats a commit that mat_ready would allow
    ar = rand_mat(); br = rand_mat();
    send_words(ar, br, 24'h0, 0, 13);
    flush = 1'b1; mat_ready = 1'b1;
    step();
    flush = 1'b0; mat_ready = 1'b0;
    check("fvc_cnt", frame_cnt, 3);
    check("fvc_keep_a", mat_a, a3);
    check("fvc_ready", wr_ready, 1);
    check("fvc_valid", mat_valid, 0);
    $display("flush over commit");

    // Counter wrap: commit until 256 frames total
    mat_ready = 1'b1;
    while (tb_cnt < 256) begin
      ar = rand_mat(); br = rand_mat();
      push_frame(ar, br);
      send_words(ar, br, 24'h0, 0, 13);
      step();
      check_commit("wrap");
    end
    mat_ready = 1'b0;
    check("wrap_cnt_zero", frame_cnt, 0);

    // Reset during word 4 of frame 257
    ar = rand_mat(); br = rand_mat();
    send_words(ar, br, 24'h0, 0, 3);
    wr_data = word_of(ar, br, 4, 24'h0); wr_valid = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; wr_valid = 1'b0;
    tb_cnt = 0;
    check("mrst_wr_ready", wr_ready, 1);
    check("mrst_mat_valid", mat_valid, 0);
    check("mrst_mat_a", mat_a, 0);
    check("mrst_mat_b", mat_b, 0);
    check("mrst_frame_cnt", frame_cnt, 0);
    check("mrst_load_err", load_err, 0);
    $display("reset mid-frame");
    ar = rand_mat(); br = rand_mat();
    push_frame(ar, br);
    send_words(ar, br, 24'h0, 0, 13);
    step();
    check_commit("after_reset");

    // Nonzero upper bytes in word 6
    push_frame(a1, b1);
    send_words(a1, b1, 24'h010000, 0, 6);
`ifdef LOAD_ERR_EN
    check("lerr_set", load_err, 1);
`else
    check("lerr_off", load_err, 0);
`endif
    send_words(a1, b1, 24'h010000, 7, 13);
    mat_ready = 1'b1;
    step();
    mat_ready = 1'b0;
    check_commit("load_err_frame");
    check("lerr_a_hi", mat_a[199:192], 8'h19);
    flush = 1'b1;
    step();
    flush = 1'b0;
`ifdef LOAD_ERR_EN
    check("lerr_sticky", load_err, 1);
`else
    check("lerr_stays_off", load_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
